game_state_controller: RTL and testbench

//  Top-level game sequencer for the Space Invaders VGA design. Owns game_status and the

---
 rtl/game_pkg.sv | 31 +++
 rtl/bcd_score_adder.sv | 30 +++
 rtl/game_state_controller.sv | 174 +++++++++++++++++
 tb/tb_game_state_controller.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared state codes, counter widths and BCD helper for the game sequencer.
package game_pkg;

    typedef enum logic [3:0] {
        ST_ATTRACT = 4'd0,
        ST_PLAY    = 4'd1,
        ST_PAUSE   = 4'd2,
        ST_DEATH   = 4'd3,
        ST_WAVE    = 4'd4,
        ST_OVER    = 4'd5
    } game_state_t;

    localparam int SCORE_W      = 16;
    localparam int LIVES_W      = 3;
    localparam int LEVEL_W      = 4;
    localparam int SCORE_DIGITS = SCORE_W / 4;

    // One BCD digit add: returns {carry_out, digit}.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] a,
                                                 input logic [3:0] b,
                                                 input logic       cin);
        logic [4:0] raw;
        raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (raw > 5'd9) begin
            return {1'b1, raw[3:0] + 4'd6};
        end else begin
            return {1'b0, raw[3:0]};
        end
    endfunction

endpackage

// File: rtl/bcd_score_adder.sv
// Combinational 4-digit BCD adder; a carry out of the top digit pins the result at 9999.
module bcd_score_adder
    import game_pkg::*;
(
    input  logic [SCORE_W-1:0] addend_a,
    input  logic [SCORE_W-1:0] addend_b,
    output logic [SCORE_W-1:0] sum
);

    // Ripple the decimal carry digit by digit, then saturate on overflow.
    always_comb begin
        logic             carry_s;
        logic [4:0]       digit_s;
        logic [SCORE_W-1:0] sum_raw_s;
        carry_s   = 1'b0;
        digit_s   = 5'd0;
        sum_raw_s = {SCORE_W{1'b0}};
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            digit_s = bcd_digit_add(addend_a[4*i +: 4], addend_b[4*i +: 4], carry_s);
            sum_raw_s[4*i +: 4] = digit_s[3:0];
            carry_s = digit_s[4];
        end
        if (carry_s) begin
            sum = 16'h9999;
        end else begin
            sum = sum_raw_s;
        end
    end

endmodule

// File: rtl/game_state_controller.sv
// Top-level game sequencer: owns game state, score, lives, level and the playfield gating.
module game_state_controller
    import game_pkg::*;
#(
    parameter logic [LIVES_W-1:0] START_LIVES  = 3'd3,
    parameter logic [SCORE_W-1:0] ALIEN_POINTS = 16'h0010,
    parameter logic [7:0]         DEATH_FRAMES = 8'd90,
    parameter logic [7:0]         WAVE_FRAMES  = 8'd120,
    parameter logic [7:0]         OVER_FRAMES  = 8'd60
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               pause,
    input  logic               alien_hit,
    input  logic               player_hit,
    input  logic               aliens_cleared,
    input  logic               aliens_landed,
    output logic [3:0]         game_status,
    output logic               run_en,
    output logic               field_reset,
    output logic [SCORE_W-1:0] score,
    output logic [LIVES_W-1:0] lives,
    output logic [LEVEL_W-1:0] level
);

    game_state_t        state_r;
    logic [7:0]         timer_r;
    logic               run_en_r;
    logic               field_reset_r;
    logic [SCORE_W-1:0] score_r;
    logic [LIVES_W-1:0] lives_r;
    logic [LEVEL_W-1:0] level_r;

    logic start_d_r, alien_d_r, player_d_r, cleared_d_r, landed_d_r;
    logic start_edge_s, alien_edge_s, player_edge_s, cleared_edge_s, landed_edge_s;
    logic [8:0]         timer_inc_s;
    logic               death_expire_s, wave_expire_s, over_ready_s;
    logic [SCORE_W-1:0] score_sum_s;

    assign start_edge_s   = start          & ~start_d_r;
    assign alien_edge_s   = alien_hit      & ~alien_d_r;
    assign player_edge_s  = player_hit     & ~player_d_r;
    assign cleared_edge_s = aliens_cleared & ~cleared_d_r;
    assign landed_edge_s  = aliens_landed  & ~landed_d_r;

    // ">=" rather than "==" so a FRAMES value of 0 expires on the first tick.
    assign timer_inc_s    = {1'b0, timer_r} + 9'd1;
    assign death_expire_s = frame_tick & (timer_inc_s >= {1'b0, DEATH_FRAMES});
    assign wave_expire_s  = frame_tick & (timer_inc_s >= {1'b0, WAVE_FRAMES});
    assign over_ready_s   = (timer_r >= OVER_FRAMES);

    bcd_score_adder u_score_adder (
        .addend_a (score_r),
        .addend_b (ALIEN_POINTS),
        .sum      (score_sum_s)
    );

    // Game FSM with its frame timer, edge-detect history and all registered outputs.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_r       <= ST_ATTRACT;
            timer_r       <= 8'd0;
            run_en_r      <= 1'b0;
            field_reset_r <= 1'b0;
            score_r       <= {SCORE_W{1'b0}};
            lives_r       <= START_LIVES;
            level_r       <= {LEVEL_W{1'b0}};
            start_d_r     <= 1'b0;
            alien_d_r     <= 1'b0;
            player_d_r    <= 1'b0;
            cleared_d_r   <= 1'b0;
            landed_d_r    <= 1'b0;
        end else begin
            start_d_r     <= start;
            alien_d_r     <= alien_hit;
            player_d_r    <= player_hit;
            cleared_d_r   <= aliens_cleared;
            landed_d_r    <= aliens_landed;
            field_reset_r <= 1'b0;

            case (state_r)
                ST_ATTRACT: begin
                    if (start_edge_s) begin
                        state_r       <= ST_PLAY;
                        run_en_r      <= 1'b1;
                        field_reset_r <= 1'b1;
                        score_r       <= {SCORE_W{1'b0}};
                        lives_r       <= START_LIVES;
                        level_r       <= {LEVEL_W{1'b0}};
                        timer_r       <= 8'd0;
                    end
                end
                ST_PLAY: begin
                    if (alien_edge_s) begin
                        score_r <= score_sum_s;
                    end
                    if (landed_edge_s) begin
                        lives_r  <= {LIVES_W{1'b0}};
                        state_r  <= ST_OVER;
                        run_en_r <= 1'b0;
                        timer_r  <= 8'd0;
                    end else if (player_edge_s) begin
                        lives_r  <= (lives_r != {LIVES_W{1'b0}}) ? lives_r - 3'd1 : {LIVES_W{1'b0}};
                        state_r  <= (lives_r <= 3'd1) ? ST_OVER : ST_DEATH;
                        run_en_r <= 1'b0;
                        timer_r  <= 8'd0;
                    end else if (cleared_edge_s) begin
                        level_r  <= (level_r == 4'd15) ? level_r : level_r + 4'd1;
                        state_r  <= ST_WAVE;
                        run_en_r <= 1'b0;
                        timer_r  <= 8'd0;
                    end else if (pause) begin
                        state_r  <= ST_PAUSE;
                        run_en_r <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (!pause) begin
                        state_r  <= ST_PLAY;
                        run_en_r <= 1'b1;
                    end
                end
                ST_DEATH: begin
                    if (death_expire_s) begin
                        state_r  <= pause ? ST_PAUSE : ST_PLAY;
                        run_en_r <= ~pause;
                        timer_r  <= 8'd0;
                    end else if (frame_tick) begin
                        timer_r <= timer_inc_s[7:0];
                    end
                end
                ST_WAVE: begin
                    if (wave_expire_s) begin
                        state_r       <= ST_PLAY;
                        run_en_r      <= 1'b1;
                        field_reset_r <= 1'b1;
                        timer_r       <= 8'd0;
                    end else if (frame_tick) begin
                        timer_r <= timer_inc_s[7:0];
                    end
                end
                ST_OVER: begin
                    // Start is only honoured once the game-over screen has been shown long enough.
                    if (start_edge_s && over_ready_s) begin
                        state_r       <= ST_PLAY;
                        run_en_r      <= 1'b1;
                        field_reset_r <= 1'b1;
                        score_r       <= {SCORE_W{1'b0}};
                        lives_r       <= START_LIVES;
                        level_r       <= {LEVEL_W{1'b0}};
                        timer_r       <= 8'd0;
                    end else if (frame_tick && !over_ready_s) begin
                        timer_r <= timer_inc_s[7:0];
                    end
                end
                default: begin
                    state_r  <= ST_ATTRACT;
                    run_en_r <= 1'b0;
                    timer_r  <= 8'd0;
                end
            endcase
        end
    end

    assign game_status = state_r;
    assign run_en      = run_en_r;
    assign field_reset = field_reset_r;
    assign score       = score_r;
    assign lives       = lives_r;
    assign level       = level_r;

endmodule

// File: tb/tb_game_state_controller.sv
// Directed vector table plus hand-written timer sequences for game_state_controller.
module tb_game_state_controller;

    logic        clk_100MHz = 1'b0;
    logic        reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        alien_hit = 1'b0;
    logic        player_hit = 1'b0;
    logic        aliens_cleared = 1'b0;
    logic        aliens_landed = 1'b0;
    logic [3:0]  game_status;
    logic        run_en;
    logic        field_reset;
    logic [15:0] score;
    logic [2:0]  lives;
    logic [3:0]  level;

    int checks = 0;
    int passed = 0;

    game_state_controller dut (
        .clk_100MHz     (clk_100MHz),
        .reset          (reset),
        .frame_tick     (frame_tick),
        .start          (start),
        .pause          (pause),
        .alien_hit      (alien_hit),
        .player_hit     (player_hit),
        .aliens_cleared (aliens_cleared),
        .aliens_landed  (aliens_landed),
        .game_status    (game_status),
        .run_en         (run_en),
        .field_reset    (field_reset),
        .score          (score),
        .lives          (lives),
        .level          (level)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    typedef struct packed {
        logic        st_in, pa_in, ah_in, ph_in, cl_in, la_in, tk_in;
        logic [3:0]  e_st;
        logic        e_run, e_fr;
        logic [15:0] e_sc;
        logic [2:0]  e_lv;
        logic [3:0]  e_lvl;
    } vec_t;

    vec_t vecs [17];

    task automatic cyc();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic expect_o(input string nm, input logic [3:0] st, input logic run,
                            input logic fr, input logic [15:0] sc, input logic [2:0] lv,
                            input logic [3:0] lvl);
        checks++;
        if ({game_status, run_en, field_reset, score, lives, level} !== {st, run, fr, sc, lv, lvl}) begin
            $display("FAIL %s: got st=%0d run=%0b fr=%0b score=%h lives=%0d level=%0d, want st=%0d run=%0b fr=%0b score=%h lives=%0d level=%0d",
                     nm, game_status, run_en, field_reset, score, lives, level, st, run, fr, sc, lv, lvl);
        end else begin
            passed++;
        end
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            cyc();
        end
    endtask

    task automatic hit();
        alien_hit = 1'b1;
        cyc();
        alien_hit = 1'b0;
        cyc();
    endtask

    function automatic vec_t mk(input logic [6:0] ins, input logic [3:0] st, input logic run,
                                input logic fr, input logic [15:0] sc, input logic [2:0] lv,
                                input logic [3:0] lvl);
        vec_t v;
        {v.st_in, v.pa_in, v.ah_in, v.ph_in, v.cl_in, v.la_in, v.tk_in} = ins;
        v.e_st = st; v.e_run = run; v.e_fr = fr; v.e_sc = sc; v.e_lv = lv; v.e_lvl = lvl;
        return v;
    endfunction

    initial begin
        // inputs: {start, pause, alien_hit, player_hit, cleared, landed, tick}
        vecs[0]  = mk(7'b0000000, 4'd0, 1'b0, 1'b0, 16'h0000, 3'd3, 4'd0);
        vecs[1]  = mk(7'b1000000, 4'd1, 1'b1, 1'b1, 16'h0000, 3'd3, 4'd0);
        vecs[2]  = mk(7'b1000000, 4'd1, 1'b1, 1'b0, 16'h0000, 3'd3, 4'd0);
        vecs[3]  = mk(7'b0000000, 4'd1, 1'b1, 1'b0, 16'h0000, 3'd3, 4'd0);
        vecs[4]  = mk(7'b0010000, 4'd1, 1'b1, 1'b0, 16'h0010, 3'd3, 4'd0);
        vecs[5]  = mk(7'b0010000, 4'd1, 1'b1, 1'b0, 16'h0010, 3'd3, 4'd0);
        vecs[6]  = mk(7'b0000000, 4'd1, 1'b1, 1'b0, 16'h0010, 3'd3, 4'd0);
        vecs[7]  = mk(7'b0010000, 4'd1, 1'b1, 1'b0, 16'h0020, 3'd3, 4'd0);
        vecs[8]  = mk(7'b0000000, 4'd1, 1'b1, 1'b0, 16'h0020, 3'd3, 4'd0);
        vecs[9]  = mk(7'b0010000, 4'd1, 1'b1, 1'b0, 16'h0030, 3'd3, 4'd0);
        vecs[10] = mk(7'b0000000, 4'd1, 1'b1, 1'b0, 16'h0030, 3'd3, 4'd0);
        vecs[11] = mk(7'b0100000, 4'd2, 1'b0, 1'b0, 16'h0030, 3'd3, 4'd0);
        vecs[12] = mk(7'b0110000, 4'd2, 1'b0, 1'b0, 16'h0030, 3'd3, 4'd0);
        vecs[13] = mk(7'b0000000, 4'd1, 1'b1, 1'b0, 16'h0030, 3'd3, 4'd0);
        vecs[14] = mk(7'b0001000, 4'd3, 1'b0, 1'b0, 16'h0030, 3'd2, 4'd0);
        vecs[15] = mk(7'b0010000, 4'd3, 1'b0, 1'b0, 16'h0030, 3'd2, 4'd0);
        vecs[16] = mk(7'b0000001, 4'd3, 1'b0, 1'b0, 16'h0030, 3'd2, 4'd0);

        cyc();
        cyc();
        expect_o("reset", 4'd0, 1'b0, 1'b0, 16'h0000, 3'd3, 4'd0);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            {start, pause, alien_hit, player_hit, aliens_cleared, aliens_landed, frame_tick} =
                {vecs[i].st_in, vecs[i].pa_in, vecs[i].ah_in, vecs[i].ph_in,
                 vecs[i].cl_in, vecs[i].la_in, vecs[i].tk_in};
            cyc();
            expect_o($sformatf("vec%0d", i), vecs[i].e_st, vecs[i].e_run, vecs[i].e_fr,
                     vecs[i].e_sc, vecs[i].e_lv, vecs[i].e_lvl);
        end
        frame_tick = 1'b0;
        cyc();

        // Death timer: one tick already counted, 88 more leave it one short.
        tick_n(88);
        expect_o("death_89", 4'd3, 1'b0, 1'b0, 16'h0030, 3'd2, 4'd0);
        frame_tick = 1'b1;
        cyc();
        expect_o("death_exp", 4'd1, 1'b1, 1'b0, 16'h0030, 3'd2, 4'd0);
        frame_tick = 1'b0;
        cyc();

        // Inter-wave pause.
        aliens_cleared = 1'b1;
        cyc();
        expect_o("wave_in", 4'd4, 1'b0, 1'b0, 16'h0030, 3'd2, 4'd1);
        aliens_cleared = 1'b0;
        cyc();
        tick_n(119);
        expect_o("wave_119", 4'd4, 1'b0, 1'b0, 16'h0030, 3'd2, 4'd1);
        frame_tick = 1'b1;
        cyc();
        expect_o("wave_exp", 4'd1, 1'b1, 1'b1, 16'h0030, 3'd2, 4'd1);
        frame_tick = 1'b0;
        cyc();
        expect_o("wave_fr_drop", 4'd1, 1'b1, 1'b0, 16'h0030, 3'd2, 4'd1);

        // Score up to saturation.
        for (int k = 0; k < 996; k++) hit();
        expect_o("score_9990", 4'd1, 1'b1, 1'b0, 16'h9990, 3'd2, 4'd1);
        hit();
        expect_o("score_sat", 4'd1, 1'b1, 1'b0, 16'h9999, 3'd2, 4'd1);
        hit();
        expect_o("score_hold", 4'd1, 1'b1, 1'b0, 16'h9999, 3'd2, 4'd1);

        // Second death, expiring with pause held.
        player_hit = 1'b1;
        cyc();
        expect_o("death2_in", 4'd3, 1'b0, 1'b0, 16'h9999, 3'd1, 4'd1);
        player_hit = 1'b0;
        cyc();
        tick_n(89);
        pause = 1'b1;
        frame_tick = 1'b1;
        cyc();
        expect_o("death_to_pause", 4'd2, 1'b0, 1'b0, 16'h9999, 3'd1, 4'd1);
        frame_tick = 1'b0;
        pause = 1'b0;
        cyc();
        expect_o("unpause", 4'd1, 1'b1, 1'b0, 16'h9999, 3'd1, 4'd1);

        // Last life.
        player_hit = 1'b1;
        cyc();
        expect_o("last_life", 4'd5, 1'b0, 1'b0, 16'h9999, 3'd0, 4'd1);
        player_hit = 1'b0;
        cyc();

        // Game over lockout.
        tick_n(10);
        start = 1'b1;
        cyc();
        expect_o("over_start10", 4'd5, 1'b0, 1'b0, 16'h9999, 3'd0, 4'd1);
        start = 1'b0;
        cyc();
        tick_n(51);
        start = 1'b1;
        cyc();
        expect_o("over_start61", 4'd1, 1'b1, 1'b1, 16'h0000, 3'd3, 4'd0);
        start = 1'b0;
        cyc();

        // Simultaneous landed + player_hit + alien_hit.
        aliens_landed = 1'b1;
        player_hit = 1'b1;
        alien_hit = 1'b1;
        cyc();
        expect_o("landed_prio", 4'd5, 1'b0, 1'b0, 16'h0010, 3'd0, 4'd0);
        {aliens_landed, player_hit, alien_hit} = 3'b000;
        cyc();

        // Lockout boundary: 59 ticks still locked, 60 releases.
        tick_n(59);
        start = 1'b1;
        cyc();
        expect_o("over_start59", 4'd5, 1'b0, 1'b0, 16'h0010, 3'd0, 4'd0);
        start = 1'b0;
        cyc();
        tick_n(1);
        start = 1'b1;
        cyc();
        expect_o("over_start60", 4'd1, 1'b1, 1'b1, 16'h0000, 3'd3, 4'd0);
        start = 1'b0;
        cyc();

        // Reset in the middle of a death freeze.
        player_hit = 1'b1;
        cyc();
        player_hit = 1'b0;
        tick_n(5);
        expect_o("death3", 4'd3, 1'b0, 1'b0, 16'h0000, 3'd2, 4'd0);
        reset = 1'b1;
        cyc();
        expect_o("mid_reset", 4'd0, 1'b0, 1'b0, 16'h0000, 3'd3, 4'd0);
        reset = 1'b0;
        cyc();
        expect_o("post_reset", 4'd0, 1'b0, 1'b0, 16'h0000, 3'd3, 4'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
